// File: rtl/usb_tx_encoder.sv
// USB low-level transmitter: SYNC, NRZI-encoded bit-stuffed payload bytes, then SE0/J end-of-packet.
// Each byte is pulled through a one-cycle ready strobe; a missing byte ends the packet and flags an error.
module usb_tx_encoder #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  input  logic       tx_last,
  output logic       tx_data_ready,
  output logic       d_plus,
  output logic       d_minus,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [3:0]    cnt, cnt_n;
  logic [2:0]    ones, ones_n;
  logic [7:0]    shreg, shreg_n;
  logic          last_byte, last_byte_n;
  logic          err, err_n;
  logic          dp_n, dm_n;
  logic          boundary, emit, emit_bit, load, go_eop;

  assign tx_busy = (state != IDLE);

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    ones_n        = ones;
    shreg_n       = shreg;
    last_byte_n   = last_byte;
    err_n         = err;
    dp_n          = d_plus;
    dm_n          = d_minus;
    emit          = 1'b0;
    emit_bit      = 1'b0;
    load          = 1'b0;
    go_eop        = 1'b0;
    tx_data_ready = 1'b0;
    tx_done       = 1'b0;
    tx_error      = 1'b0;
    boundary      = (state != IDLE) && (timer == T_LAST);
    timer_n       = ((state == IDLE) || boundary) ? '0 : timer + TW'(1);

    case (state)
      IDLE: begin
        // First sync bit is a raw 0, so the line leaves J for K on the sampling edge.
        if (tx_start) begin
          state_n = SYNC;
          cnt_n   = '0;
          ones_n  = '0;
          err_n   = 1'b0;
          dp_n    = 1'b0;
          dm_n    = 1'b1;
        end
      end
      SYNC: begin
        if (boundary) begin
          if (cnt == 4'd7) begin
            tx_data_ready = 1'b1;
            load          = 1'b1;
          end else begin
            cnt_n    = cnt + 4'd1;
            emit     = 1'b1;
            emit_bit = (cnt == 4'd6);
          end
        end
      end
      DATA: begin
        // cnt holds the number of bits of the current byte already on the wire.
        if (boundary) begin
          if (ones == 3'd6) begin
            emit = 1'b1;
          end else if (cnt == 4'd8) begin
            if (last_byte) begin
              go_eop = 1'b1;
            end else begin
              tx_data_ready = 1'b1;
              load          = 1'b1;
            end
          end else begin
            emit     = 1'b1;
            emit_bit = shreg[cnt[2:0]];
            cnt_n    = cnt + 4'd1;
          end
        end
      end
      EOP_SE0: begin
        if (boundary) begin
          if (cnt == 4'd1) begin
            state_n = EOP_J;
            dp_n    = 1'b1;
            dm_n    = 1'b0;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
      end
      EOP_J: begin
        if (boundary) begin
          tx_done  = 1'b1;
          tx_error = err;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (load) begin
      if (tx_data_valid) begin
        shreg_n     = tx_data;
        last_byte_n = tx_last;
        state_n     = DATA;
        cnt_n       = 4'd1;
        emit        = 1'b1;
        emit_bit    = tx_data[0];
      end else begin
        err_n  = 1'b1;
        go_eop = 1'b1;
      end
    end

    if (go_eop) begin
      state_n = EOP_SE0;
      cnt_n   = '0;
      dp_n    = 1'b0;
      dm_n    = 1'b0;
    end

    // NRZI: a raw 0 flips J<->K, a raw 1 holds the line.
    if (emit) begin
      if (!emit_bit) begin
        dp_n = ~d_plus;
        dm_n = ~d_minus;
      end
      ones_n = emit_bit ? ones + 3'd1 : 3'd0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      timer     <= '0;
      cnt       <= '0;
      ones      <= '0;
      shreg     <= '0;
      last_byte <= 1'b0;
      err       <= 1'b0;
      d_plus    <= 1'b1;
      d_minus   <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      cnt       <= cnt_n;
      ones      <= ones_n;
      shreg     <= shreg_n;
      last_byte <= last_byte_n;
      err       <= err_n;
      d_plus    <= dp_n;
      d_minus   <= dm_n;
    end
  end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Directed bench for usb_tx_encoder: line patterns, stuffing, handshake, underrun, reset abort, 2 clk/bit.
module tb_usb_tx_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       n_rst, start8, start2, tx_data_valid, tx_last;
  logic [7:0] tx_data;
  logic       rdy8, dp8, dm8, busy8, done8, err8;
  logic       rdy2, dp2, dm2, busy2, done2, err2;

  usb_tx_encoder #(.CLKS_PER_BIT(8)) u8 (
    .clk(clk), .n_rst(n_rst), .tx_start(start8), .tx_data(tx_data),
    .tx_data_valid(tx_data_valid), .tx_last(tx_last), .tx_data_ready(rdy8),
    .d_plus(dp8), .d_minus(dm8), .tx_busy(busy8), .tx_done(done8), .tx_error(err8)
  );

  usb_tx_encoder #(.CLKS_PER_BIT(2)) u2 (
    .clk(clk), .n_rst(n_rst), .tx_start(start2), .tx_data(tx_data),
    .tx_data_valid(tx_data_valid), .tx_last(tx_last), .tx_data_ready(rdy2),
    .d_plus(dp2), .d_minus(dm2), .tx_busy(busy2), .tx_done(done2), .tx_error(err2)
  );

  logic use2;
  logic rdy, dp, dm, busy, done, err;
  assign rdy  = use2 ? rdy2  : rdy8;
  assign dp   = use2 ? dp2   : dp8;
  assign dm   = use2 ? dm2   : dm8;
  assign busy = use2 ? busy2 : busy8;
  assign done = use2 ? done2 : done8;
  assign err  = use2 ? err2  : err8;

  int    checks = 0;
  int    errors = 0;
  string line;
  int    done_cyc, err_stray, restart_cyc, underrun_at, npkt, stuff_bad;
  logic  err_at_done, busy_at_start;
  int    ready_cyc[$];
  logic [7:0] pkt[4];
  logic [7:0] dec_sync;
  logic [7:0] dec_byte[3];
  int    dec_len;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic check_s(input string tag, input string got, input string exp);
    checks++;
    assert (got == exp) else begin
      errors++;
      $error("FAIL %s: observed '%s' expected '%s'", tag, got, exp);
    end
  endtask

  function automatic string line_char();
    if (dp && !dm)  return "J";
    if (!dp && dm)  return "K";
    if (!dp && !dm) return "0";
    return "X";
  endfunction

  function automatic int rc(input int k);
    return (ready_cyc.size() > k) ? ready_cyc[k] : -1;
  endfunction

  // Drives one packet from pkt[0..npkt-1]; samples the line mid-bit and logs handshake/done timing.
  task automatic run_pkt(input int max_cyc);
    int idx;
    int cpb;
    bit take;
    idx = 0;
    cpb = use2 ? 2 : 8;
    line = "";
    done_cyc = -1;
    err_at_done = 1'b0;
    err_stray = 0;
    ready_cyc.delete();
    tx_data = pkt[0];
    tx_last = (npkt == 1);
    tx_data_valid = (underrun_at != 0);
    @(negedge clk);
    busy_at_start = busy;
    if (use2) start2 = 1'b1; else start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0; start2 = 1'b0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      @(negedge clk);
      if (cyc % cpb == cpb / 2) line = {line, line_char()};
      if (err && !done) err_stray++;
      take = rdy && tx_data_valid;
      if (rdy) ready_cyc.push_back(cyc);
      if (done) begin
        done_cyc = cyc;
        err_at_done = err;
        break;
      end
      if (cyc == restart_cyc) begin
        if (use2) start2 = 1'b1; else start8 = 1'b1;
      end
      @(posedge clk);
      #1 start8 = 1'b0; start2 = 1'b0;
      if (take) begin
        idx++;
        if (idx < npkt) begin
          tx_data = pkt[idx];
          tx_last = (idx == npkt - 1);
          tx_data_valid = (underrun_at != idx);
        end else begin
          tx_data_valid = 1'b0;
        end
      end
    end
  endtask

  // NRZI decode from idle J, then strip the 0 that follows every six consecutive 1s.
  task automatic decode(input string s);
    byte c, prev;
    bit  raw;
    int  ones;
    bit  q[$];
    prev = "J";
    ones = 0;
    stuff_bad = 0;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c != "J" && c != "K") break;
      raw = (c == prev);
      prev = c;
      if (ones == 6) begin
        if (raw) stuff_bad++;
        ones = 0;
      end else begin
        q.push_back(raw);
        ones = raw ? ones + 1 : 0;
      end
    end
    dec_len = q.size();
    while (q.size() < 32) q.push_back(1'b0);
    for (int k = 0; k < 8; k++) dec_sync[k] = q[k];
    for (int j = 0; j < 3; j++)
      for (int k = 0; k < 8; k++) dec_byte[j][k] = q[8 + 8 * j + k];
  endtask

  initial begin
    int bad;
    n_rst = 1'b0;
    start8 = 1'b0;
    start2 = 1'b0;
    use2 = 1'b0;
    tx_data = 8'h00;
    tx_data_valid = 1'b0;
    tx_last = 1'b0;
    restart_cyc = -1;
    underrun_at = -1;
    npkt = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset8_outputs", {dp8, dm8, busy8, done8, err8, rdy8}, 6'b100000);
    check("reset2_outputs", {dp2, dm2, busy2, done2, err2, rdy2}, 6'b100000);
    n_rst = 1'b1;
    @(negedge clk);

    // Single 0x00 byte: sync then alternating line.
    pkt[0] = 8'h00; npkt = 1;
    run_pkt(400);
    check_s("line_00", line, "KJKJKJKKJKJKJKJK00J");
    check("done_00", done_cyc, 151);
    check("err_00", err_at_done, 0);
    check("ready_n_00", ready_cyc.size(), 1);
    check("ready_at_00", rc(0), 63);

    // Back-to-back start right after tx_done, 0xFF forces a stuff bit.
    pkt[0] = 8'hFF;
    run_pkt(400);
    check("b2b_idle_before_start", busy_at_start, 0);
    check_s("line_ff", line, "KJKJKJKKKKKKKJJJJ00J");
    check("done_ff", done_cyc, 159);

    // Three bytes with valid held throughout.
    pkt[0] = 8'hA5; pkt[1] = 8'h3C; pkt[2] = 8'h7E; npkt = 3;
    run_pkt(600);
    decode(line);
    check("sync_3b", dec_sync, 8'h80);
    check("bits_3b", dec_len, 32);
    check("byte0_3b", dec_byte[0], 8'hA5);
    check("byte1_3b", dec_byte[1], 8'h3C);
    check("byte2_3b", dec_byte[2], 8'h7E);
    check("stuff_3b", stuff_bad, 0);
    check("ready_n_3b", ready_cyc.size(), 3);
    check("ready0_3b", rc(0), 63);
    check("ready1_3b", rc(1), 127);
    check("ready2_3b", rc(2), 191);
    check("done_3b", done_cyc, 287);

    // Underrun on the second byte.
    pkt[0] = 8'h55; pkt[1] = 8'h99; npkt = 2; underrun_at = 1;
    run_pkt(400);
    underrun_at = -1;
    check_s("line_ur", line, "KJKJKJKKKJJKKJJK00J");
    check("done_ur", done_cyc, 151);
    check("err_ur", err_at_done, 1);
    check("err_stray_ur", err_stray, 0);
    check("ready_n_ur", ready_cyc.size(), 2);

    // Reset in the middle of byte 2 aborts without EOP.
    pkt[0] = 8'hA5; pkt[1] = 8'h3C; npkt = 2;
    run_pkt(160);
    n_rst = 1'b0;
    #1;
    check("rst_mid_outputs", {dp8, dm8, busy8, rdy8, done8, err8}, 6'b100000);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (!(dp8 && !dm8) || busy8) bad++;
    end
    n_rst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!(dp8 && !dm8) || busy8) bad++;
    end
    check("rst_no_eop", bad, 0);
    pkt[0] = 8'h00; npkt = 1;
    run_pkt(400);
    check_s("line_after_rst", line, "KJKJKJKKJKJKJKJK00J");
    check("done_after_rst", done_cyc, 151);

    // tx_start while busy is ignored.
    restart_cyc = 50;
    run_pkt(400);
    restart_cyc = -1;
    check_s("line_restart", line, "KJKJKJKKJKJKJKJK00J");
    check("done_restart", done_cyc, 151);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy8) bad++;
    end
    check("no_second_pkt", bad, 0);

    // Same packet at 2 clocks per bit.
    use2 = 1'b1;
    run_pkt(200);
    check_s("line_cpb2", line, "KJKJKJKKJKJKJKJK00J");
    check("done_cpb2", done_cyc, 37);
    check("ready_at_cpb2", rc(0), 15);
    use2 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
